// File: rtl/carbon_csr_arb_pkg.sv
// Shared types for the CSR request arbiter: FSM state encoding and the rdata
// returned with a synthesized timeout fault.
package carbon_csr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [63:0] TIMEOUT_RDATA = 64'h0;

endpackage

// File: rtl/carbon_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_grant,
// wrapping modulo N_REQ. Returns one-hot grant, its index and an any-valid flag.
module carbon_rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             any_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % N_REQ);
      if (!any_c && req[cand]) begin
        any_c         = 1'b1;
        idx_c         = cand;
        grant_c[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/caprom_csr_arbiter.sv
// Round-robin arbiter sharing one CSR slave among N_REQ requesters, one
// transaction in flight. Optional WAIT timeout via CARBON_CSR_ARB_TIMEOUT_EN.
module caprom_csr_arbiter
  import carbon_csr_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 3,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          m_req_valid,
  output logic [N_REQ-1:0]          m_req_ready,
  input  logic [N_REQ-1:0]          m_req_write,
  input  logic [N_REQ*ADDR_W-1:0]   m_req_addr,
  input  logic [N_REQ*DATA_W-1:0]   m_req_wdata,
  output logic [N_REQ-1:0]          m_rsp_valid,
  input  logic [N_REQ-1:0]          m_rsp_ready,
  output logic [DATA_W-1:0]         m_rsp_rdata,
  output logic                      m_rsp_fault,
  output logic                      m_rsp_side_effect,
  output logic                      s_req_valid,
  input  logic                      s_req_ready,
  output logic                      s_req_write,
  output logic [ADDR_W-1:0]         s_req_addr,
  output logic [DATA_W-1:0]         s_req_wdata,
  input  logic                      s_rsp_valid,
  output logic                      s_rsp_ready,
  input  logic [DATA_W-1:0]         s_rsp_rdata,
  input  logic                      s_rsp_fault,
  input  logic                      s_rsp_side_effect,
  output logic                      busy
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || ADDR_W < 1 || DATA_W < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("caprom_csr_arbiter: parameter out of range");
  end

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic              side_q, side_d;
  logic [N_REQ-1:0]  m_rsp_valid_q, m_rsp_valid_d;
  logic              s_req_valid_q, s_req_valid_d;
  logic              s_rsp_ready_q, s_rsp_ready_d;
  logic              busy_q, busy_d;

  logic [N_REQ-1:0]  pick_grant_c;
  logic [IDX_W-1:0]  pick_idx_c;
  logic              pick_any_c;

`ifdef CARBON_CSR_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  carbon_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (m_req_valid),
    .last_grant (last_grant_q),
    .grant_c    (pick_grant_c),
    .idx_c      (pick_idx_c),
    .any_c      (pick_any_c)
  );

  // Next-state, holding/response capture and registered-output precompute
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_idx_d  = grant_idx_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    fault_d      = fault_q;
    side_d       = side_q;
    m_req_ready  = '0;
`ifdef CARBON_CSR_ARB_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        m_req_ready = pick_grant_c;
        if (pick_any_c) begin
          grant_idx_d = pick_idx_c;
          write_d     = m_req_write[pick_idx_c];
          addr_d      = m_req_addr[32'(pick_idx_c) * ADDR_W +: ADDR_W];
          wdata_d     = m_req_wdata[32'(pick_idx_c) * DATA_W +: DATA_W];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (s_req_ready) begin
          state_d = WAIT;
`ifdef CARBON_CSR_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      WAIT: begin
`ifdef CARBON_CSR_ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
`endif
        if (s_rsp_valid) begin
          rdata_d = s_rsp_rdata;
          fault_d = s_rsp_fault;
          side_d  = s_rsp_side_effect;
          state_d = RESP;
        end
`ifdef CARBON_CSR_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rdata_d = DATA_W'(TIMEOUT_RDATA);
          fault_d = 1'b1;
          side_d  = 1'b0;
          state_d = RESP;
        end
`endif
      end
      RESP: begin
        if (m_rsp_ready[grant_idx_q]) begin
          last_grant_d = grant_idx_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    s_req_valid_d = (state_d == ISSUE);
    s_rsp_ready_d = (state_d == IDLE) || (state_d == WAIT);
    busy_d        = (state_d != IDLE);
    m_rsp_valid_d = (state_d == RESP) ? (N_REQ'(1) << grant_idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_grant_q  <= IDX_W'(N_REQ - 1);
      grant_idx_q   <= '0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      fault_q       <= 1'b0;
      side_q        <= 1'b0;
      m_rsp_valid_q <= '0;
      s_req_valid_q <= 1'b0;
      s_rsp_ready_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef CARBON_CSR_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_idx_q   <= grant_idx_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      fault_q       <= fault_d;
      side_q        <= side_d;
      m_rsp_valid_q <= m_rsp_valid_d;
      s_req_valid_q <= s_req_valid_d;
      s_rsp_ready_q <= s_rsp_ready_d;
      busy_q        <= busy_d;
`ifdef CARBON_CSR_ARB_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign m_rsp_valid       = m_rsp_valid_q;
  assign m_rsp_rdata       = rdata_q;
  assign m_rsp_fault       = fault_q;
  assign m_rsp_side_effect = side_q;
  assign s_req_valid       = s_req_valid_q;
  assign s_req_write       = write_q;
  assign s_req_addr        = addr_q;
  assign s_req_wdata       = wdata_q;
  assign s_rsp_ready       = s_rsp_ready_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_caprom_csr_arbiter.sv
// Directed bench for caprom_csr_arbiter: requester/slave models with a response
// scoreboard; the timeout scenario runs when CARBON_CSR_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_caprom_csr_arbiter;

  localparam int N   = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam logic [31:0] RD_BASE = 32'h4353_4443;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_req_valid, m_req_ready, m_req_write, m_rsp_valid, m_rsp_ready;
  logic [N*AW-1:0] m_req_addr;
  logic [N*DW-1:0] m_req_wdata;
  logic [DW-1:0]   m_rsp_rdata;
  logic            m_rsp_fault, m_rsp_side_effect;
  logic            s_req_valid, s_req_ready, s_req_write;
  logic [AW-1:0]   s_req_addr;
  logic [DW-1:0]   s_req_wdata, s_rsp_rdata;
  logic            s_rsp_valid, s_rsp_ready, s_rsp_fault, s_rsp_side_effect, busy;

  always #5 clk = ~clk;

  caprom_csr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_write(m_req_write),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
    .m_rsp_fault(m_rsp_fault), .m_rsp_side_effect(m_rsp_side_effect),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_write(s_req_write),
    .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
    .s_rsp_fault(s_rsp_fault), .s_rsp_side_effect(s_rsp_side_effect), .busy(busy)
  );

  typedef struct { int idx; logic [31:0] rdata; logic fault; logic side; } rsp_t;
  typedef struct { logic write; logic [31:0] addr; logic [31:0] wdata; } req_t;

  rsp_t rsp_q[$];
  req_t req_q[$];
  int   grant_log[$];
  int   lat_q[$];
  int   n_checks = 0, n_pass = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0, rsp_first_cyc = 0, wait_start = 0, n_done = 0;
  bit   rsp_seen = 0;

  // slave behaviour knobs, written only by the main sequence
  int   sl_req_wait = 0, sl_rsp_wait = 0;
  bit   sl_fault = 0, sl_side = 0, sl_silent = 0, tmo_mode = 0;
  int   stray_req = 0, stray_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Requester-side monitor and response scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (m_req_valid[i] && m_req_ready[i]) begin
          rsp_t e;
          req_t r;
          chk("req_ready_onehot", 64'(m_req_ready), 64'(N'(1) << i));
          r.write = m_req_write[i];
          r.addr  = m_req_addr[i*AW +: AW];
          r.wdata = m_req_wdata[i*DW +: DW];
          e.idx   = i;
          e.rdata = tmo_mode ? 32'h0 : RD_BASE + r.addr;
          e.fault = tmo_mode ? 1'b1 : sl_fault;
          e.side  = tmo_mode ? 1'b0 : sl_side;
          req_q.push_back(r);
          rsp_q.push_back(e);
          grant_log.push_back(i);
          acc_cyc = cyc;
        end
      end
      if (busy) chk("ready_while_busy", 64'(m_req_ready), 64'(0));
      if (m_rsp_valid != '0) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 64'(m_rsp_valid), 64'(0));
        else begin
          rsp_t e;
          e = rsp_q[0];
          if (!rsp_seen) begin
            rsp_seen = 1;
            rsp_first_cyc = cyc;
            lat_q.push_back(cyc - acc_cyc);
          end
          chk("rsp_valid_onehot", 64'(m_rsp_valid), 64'(N'(1) << e.idx));
          chk("rsp_rdata", 64'(m_rsp_rdata), 64'(e.rdata));
          chk("rsp_fault", 64'(m_rsp_fault), 64'(e.fault));
          chk("rsp_side_effect", 64'(m_rsp_side_effect), 64'(e.side));
          if (m_rsp_ready[e.idx]) begin
            void'(rsp_q.pop_front());
            rsp_seen = 0;
            n_done++;
          end
        end
      end
    end
  end

  // Slave model: programmable request-accept and response delays
  initial begin
    bit pending;
    int req_cnt, rsp_cnt;
    logic [31:0] rsp_data;
    pending = 0; req_cnt = 0; rsp_cnt = 0; rsp_data = '0;
    s_req_ready = 0; s_rsp_valid = 0; s_rsp_rdata = '0; s_rsp_fault = 0; s_rsp_side_effect = 0;
    forever begin
      @(negedge clk);
      s_rsp_valid = 0; s_rsp_rdata = '0; s_rsp_fault = 0; s_rsp_side_effect = 0;
      s_req_ready = 0;
      if (!rst_n) begin
        pending = 0; req_cnt = 0; rsp_cnt = 0;
      end else begin
        if (stray_req != stray_done) begin
          stray_done = stray_req;
          s_rsp_valid = 1; s_rsp_rdata = 32'hDEAD_BEEF; s_rsp_fault = 1; s_rsp_side_effect = 1;
        end else if (pending) begin
          chk("wait_s_rsp_ready", 64'(s_rsp_ready), 64'(1));
          chk("wait_s_req_valid", 64'(s_req_valid), 64'(0));
          if (rsp_cnt == sl_rsp_wait) begin
            s_rsp_valid = 1; s_rsp_rdata = rsp_data;
            s_rsp_fault = sl_fault; s_rsp_side_effect = sl_side;
            pending = 0; rsp_cnt = 0;
          end else rsp_cnt++;
        end
        if (s_req_valid) begin
          if (req_cnt == sl_req_wait) begin
            s_req_ready = 1; req_cnt = 0;
            if (req_q.size() == 0) chk("slave_req_unexpected", 64'(s_req_valid), 64'(0));
            else begin
              req_t r;
              r = req_q.pop_front();
              chk("slave_write", 64'(s_req_write), 64'(r.write));
              chk("slave_addr", 64'(s_req_addr), 64'(r.addr));
              if (r.write) chk("slave_wdata", 64'(s_req_wdata), 64'(r.wdata));
            end
            rsp_data   = RD_BASE + s_req_addr;
            pending    = !sl_silent;
            wait_start = cyc + 1;
          end else req_cnt++;
        end else req_cnt = 0;
      end
    end
  end

  task automatic wait_accept(input int i, output logic [N-1:0] rdy);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(m_req_valid[i] && m_req_ready[i]) && k < 200);
    rdy = m_req_ready;
    chk("accept_seen", 64'(m_req_ready[i]), 64'(1));
    @(posedge clk); #1;
    m_req_valid[i] = 1'b0;
  endtask

  task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [N-1:0] rdy);
    @(posedge clk); #1;
    m_req_write[i] = w;
    m_req_addr[i*AW +: AW] = a;
    m_req_wdata[i*DW +: DW] = d;
    m_req_valid[i] = 1'b1;
    wait_accept(i, rdy);
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (n_done < target && k < 400) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("done_count", 64'(n_done), 64'(target));
  endtask

  initial begin
    logic [N-1:0] rdy;
    int base, k;
    rst_n = 0;
    m_req_valid = '0; m_req_write = '0; m_req_addr = '0; m_req_wdata = '0;
    m_rsp_ready = '1;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_rsp_valid", 64'(m_rsp_valid), 64'(0));
    chk("rst_s_req_valid", 64'(s_req_valid), 64'(0));
    chk("rst_s_rsp_ready", 64'(s_rsp_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(negedge clk);
    chk("idle_s_rsp_ready", 64'(s_rsp_ready), 64'(1));

    // requester 1 reads addr 0x0 with a zero-wait slave
    lat_q.delete();
    base = n_done;
    issue(1, 1'b0, 32'h0, 32'h0, rdy);
    chk("t1_accept_ready", 64'(rdy), 64'(3'b010));
    wait_done(base + 1);
    chk("t1_latency", 64'(lat_q.size() > 0 ? lat_q[0] : -1), 64'(3));

    // requester 2 write returning fault and side effect
    sl_fault = 1; sl_side = 1;
    base = n_done;
    issue(2, 1'b1, 32'h8, 32'hA5A5_0008, rdy);
    wait_done(base + 1);
    sl_fault = 0; sl_side = 0;

    // all three hold valid: round-robin order from last grant 2
    grant_log.delete();
    base = n_done;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) m_req_addr[i*AW +: AW] = 32'(i * 4 + 16);
    m_req_write = '0;
    m_req_valid = '1;
    k = 0;
    while (grant_log.size() < 4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1 m_req_valid = '0;
    wait_done(base + 4);
    chk("rr_grant_count", 64'(grant_log.size()), 64'(4));
    for (int j = 0; j < 4; j++)
      chk("rr_grant_order", 64'(j < grant_log.size() ? grant_log[j] : -1), 64'(j % N));

    // slave stalls: 5 cycles without s_req_ready, 4 without s_rsp_valid
    sl_req_wait = 5; sl_rsp_wait = 4;
    lat_q.delete();
    base = n_done;
    issue(0, 1'b0, 32'h20, 32'h0, rdy);
    @(posedge clk); #1;
    m_req_addr[1*AW +: AW] = 32'h24;
    m_req_valid[1] = 1'b1;
    wait_accept(1, rdy);
    wait_done(base + 2);
    chk("stall_lat0", 64'(lat_q.size() > 0 ? lat_q[0] : -1), 64'(12));
    chk("stall_lat1", 64'(lat_q.size() > 1 ? lat_q[1] : -1), 64'(12));
    sl_req_wait = 0; sl_rsp_wait = 0;

    // granted requester back-pressures the response for 10 cycles
    grant_log.delete();
    base = n_done;
    m_rsp_ready = 3'b110;
    issue(0, 1'b0, 32'h30, 32'h0, rdy);
    m_req_addr[2*AW +: AW] = 32'h34;
    m_req_valid[2] = 1'b1;
    k = 0;
    while (!m_rsp_valid[0] && k < 50) begin
      @(negedge clk);
      k++;
    end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(m_rsp_valid), 64'(3'b001));
      chk("hold_rsp_rdata", 64'(m_rsp_rdata), 64'(RD_BASE + 32'h30));
    end
    @(posedge clk); #1 m_rsp_ready = 3'b111;
    wait_accept(2, rdy);
    wait_done(base + 2);
    chk("hold_grant_count", 64'(grant_log.size()), 64'(2));
    chk("hold_grant_second", 64'(grant_log.size() > 1 ? grant_log[1] : -1), 64'(2));

`ifdef CARBON_CSR_ARB_TIMEOUT_EN
    // silent slave: fault response TMO cycles after entering WAIT
    tmo_mode = 1; sl_silent = 1;
    base = n_done;
    issue(1, 1'b0, 32'h10, 32'h0, rdy);
    wait_done(base + 1);
    chk("tmo_delay", 64'(rsp_first_cyc - wait_start), 64'(TMO));
    tmo_mode = 0; sl_silent = 0;
`endif

    // stray slave response in IDLE is consumed silently
    @(posedge clk); #1 stray_req++;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("stray_no_rsp", 64'(m_rsp_valid), 64'(0));
      chk("stray_idle", 64'(busy), 64'(0));
    end
    base = n_done;
    issue(1, 1'b0, 32'h40, 32'h0, rdy);
    wait_done(base + 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(rsp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
